// File: rtl/instr_decode_unit_if.sv
// Bus between code memory / control FSM and the i281 instruction decode unit.
// The control side drives the load strobes; the decode unit returns opcode, flags and debug count.
interface instr_decode_unit_if #(
   parameter int CNT_W = 16
);
   logic [15:0]      instr_in;
   logic             ir_load;
   logic             flags_load;
   logic [3:0]       alu_flags_in;
   logic [26:0]      opcode_out;
   logic [7:0]       imm_out;
   logic [3:0]       flags_reg;
   logic             opcode_valid;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output instr_in, ir_load, flags_load, alu_flags_in,
      input  opcode_out, imm_out, flags_reg, opcode_valid, fetch_count
   );

   modport slave (
      input  instr_in, ir_load, flags_load, alu_flags_in,
      output opcode_out, imm_out, flags_reg, opcode_valid, fetch_count
   );
endinterface

// File: rtl/instr_decode_unit.sv
// i281 instruction register, one-hot opcode decoder, flags register and
// saturating fetch counter. Decode is purely combinational from the IR.
module instr_decode_unit #(
   parameter int CNT_W = 16
) (
   input  logic          clock,
   input  logic          reset,
   instr_decode_unit_if.slave bus
);

   logic [15:0]      r_ir;
   logic [3:0]       r_flags;
   logic             r_valid;
   logic [CNT_W-1:0] r_fetch_count;

   logic [3:0]       w_op;
   logic [1:0]       w_rx;
   logic [1:0]       w_ry;
   logic [22:0]      w_onehot;
   logic             w_cnt_sat;

   assign w_op      = r_ir[15:12];
   assign w_rx      = r_ir[11:10];
   assign w_ry      = r_ir[9:8];
   assign w_cnt_sat = &r_fetch_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ir          <= 16'h0000;
         r_flags       <= 4'b0000;
         r_valid       <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         if (bus.ir_load) begin
            r_ir    <= bus.instr_in;
            r_valid <= 1'b1;
            if (!w_cnt_sat)
               r_fetch_count <= r_fetch_count + CNT_W'(1);
         end
         if (bus.flags_load)
            r_flags <= bus.alu_flags_in;
      end
   end

   // Every IR value maps to exactly one class; sub-selects use RY (or RY[0] for shifts).
   always_comb begin
      w_onehot = '0;
      case (w_op)
         4'h0: w_onehot[0] = 1'b1;
         4'h1: begin
            case (w_ry)
               2'b00:   w_onehot[1] = 1'b1;
               2'b01:   w_onehot[2] = 1'b1;
               2'b10:   w_onehot[3] = 1'b1;
               default: w_onehot[4] = 1'b1;
            endcase
         end
         4'h2: w_onehot[5]  = 1'b1;
         4'h3: w_onehot[6]  = 1'b1;
         4'h4: w_onehot[7]  = 1'b1;
         4'h5: w_onehot[8]  = 1'b1;
         4'h6: w_onehot[9]  = 1'b1;
         4'h7: w_onehot[10] = 1'b1;
         4'h8: w_onehot[11] = 1'b1;
         4'h9: w_onehot[12] = 1'b1;
         4'hA: w_onehot[13] = 1'b1;
         4'hB: w_onehot[14] = 1'b1;
         4'hC: begin
            if (w_ry[0])
               w_onehot[16] = 1'b1;
            else
               w_onehot[15] = 1'b1;
         end
         4'hD: w_onehot[17] = 1'b1;
         4'hE: w_onehot[18] = 1'b1;
         default: begin
            case (w_ry)
               2'b00:   w_onehot[19] = 1'b1;
               2'b01:   w_onehot[20] = 1'b1;
               2'b10:   w_onehot[21] = 1'b1;
               default: w_onehot[22] = 1'b1;
            endcase
         end
      endcase
   end

   assign bus.opcode_out   = {w_rx, w_ry, w_onehot};
   assign bus.imm_out      = r_ir[7:0];
   assign bus.flags_reg    = r_flags;
   assign bus.opcode_valid = r_valid;
   assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Directed self-checking bench for instr_decode_unit, built with a 4-bit
// fetch counter so saturation is reachable quickly.
module tb_instr_decode_unit;
   localparam int CNT_W = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   instr_decode_unit_if #(.CNT_W(CNT_W)) bus ();

   instr_decode_unit #(.CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;
   int base_bit[16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [26:0] exp_op(input logic [15:0] w);
      int b;
      logic [22:0] oh;
      b = base_bit[w[15:12]];
      if (w[15:12] == 4'h1 || w[15:12] == 4'hF) b = b + int'(w[9:8]);
      if (w[15:12] == 4'hC) b = b + int'(w[8]);
      oh = 23'd1 << b;
      return {w[11:10], w[9:8], oh};
   endfunction

   task automatic load(input logic [15:0] w);
      @(negedge clock);
      bus.instr_in = w;
      bus.ir_load  = 1'b1;
      @(posedge clock);
      #1;
      bus.ir_load = 1'b0;
      if (exp_cnt < 15) exp_cnt++;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_op"},    32'(bus.opcode_out),   32'h0000001);
      check({tag, "_imm"},   32'(bus.imm_out),      32'h0);
      check({tag, "_flags"}, 32'(bus.flags_reg),    32'h0);
      check({tag, "_valid"}, 32'(bus.opcode_valid), 32'h0);
      check({tag, "_cnt"},   32'(bus.fetch_count),  32'h0);
   endtask

   initial begin
      logic [15:0] w;
      bus.instr_in     = 16'h0000;
      bus.ir_load      = 1'b0;
      bus.flags_load   = 1'b0;
      bus.alu_flags_in = 4'b0000;

      #12;
      check_reset_state("rst0");
      @(negedge clock);
      reset = 1'b0;

      // full decode sweep, RX = 10
      for (int op = 0; op < 16; op++) begin
         for (int ry = 0; ry < 4; ry++) begin
            w = {op[3:0], 2'b10, ry[1:0], op[3:0], ry[1:0], 2'b01};
            load(w);
            check($sformatf("sweep_op_%h", w), 32'(bus.opcode_out), 32'(exp_op(w)));
            check($sformatf("sweep_imm_%h", w), 32'(bus.imm_out), 32'(w[7:0]));
         end
      end
      check("sweep_valid", 32'(bus.opcode_valid), 32'h1);
      check("sweep_cnt", 32'(bus.fetch_count), 32'(exp_cnt));

      load(16'hF6A5);
      check("brg_op",  32'(bus.opcode_out), 32'({2'b01, 2'b10, 23'(1) << 21}));
      check("brg_imm", 32'(bus.imm_out), 32'hA5);

      // hold: instr_in changes without ir_load
      @(negedge clock);
      bus.instr_in = 16'h4000;
      @(posedge clock);
      #1;
      check("hold_op",  32'(bus.opcode_out), 32'({2'b01, 2'b10, 23'(1) << 21}));
      check("hold_cnt", 32'(bus.fetch_count), 32'(exp_cnt));

      // flags
      @(negedge clock);
      bus.alu_flags_in = 4'b0011;
      bus.flags_load   = 1'b1;
      #1;
      check("flags_before_edge", 32'(bus.flags_reg), 32'h0);
      @(posedge clock);
      #1;
      check("flags_load", 32'(bus.flags_reg), 32'h3);
      @(negedge clock);
      bus.alu_flags_in = 4'b1000;
      bus.flags_load   = 1'b0;
      @(posedge clock);
      #1;
      check("flags_hold", 32'(bus.flags_reg), 32'h3);
      @(negedge clock);
      bus.instr_in   = 16'hD000;
      bus.ir_load    = 1'b1;
      bus.flags_load = 1'b1;
      @(posedge clock);
      #1;
      bus.ir_load    = 1'b0;
      bus.flags_load = 1'b0;
      if (exp_cnt < 15) exp_cnt++;
      check("simul_op",    32'(bus.opcode_out), 32'h0020000);
      check("simul_flags", 32'(bus.flags_reg), 32'h8);

      // reset mid-stream
      load(16'h8123);
      check("ld8123_op", 32'(bus.opcode_out), 32'({2'b00, 2'b01, 23'(1) << 11}));
      @(negedge clock);
      bus.instr_in     = 16'h5555;
      bus.ir_load      = 1'b1;
      bus.alu_flags_in = 4'hF;
      bus.flags_load   = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("rst_async");
      @(posedge clock);
      #1;
      check_reset_state("rst_held");
      @(negedge clock);
      reset          = 1'b0;
      bus.ir_load    = 1'b0;
      bus.flags_load = 1'b0;
      exp_cnt        = 0;

      load(16'h2400);
      check("move_op",    32'(bus.opcode_out), 32'({2'b01, 2'b00, 23'(1) << 5}));
      check("move_valid", 32'(bus.opcode_valid), 32'h1);
      check("move_cnt",   32'(bus.fetch_count), 32'h1);

      // saturation: pulses 2..20
      for (int i = 2; i <= 20; i++) begin
         w = {8'hE0, i[7:0]};
         load(w);
         check($sformatf("sat_cnt_%0d", i), 32'(bus.fetch_count), (i < 15) ? 32'(i) : 32'hF);
      end
      check("sat_op",  32'(bus.opcode_out), 32'h0040000);
      check("sat_imm", 32'(bus.imm_out), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/instr_decode_unit.md
# instr_decode_unit

Instruction register and opcode decoder for the i281 multicycle CPU. Latches the 16-bit instruction word from code memory when the control FSM asserts the IR-load control bit. Presents the 27-bit decoded opcode bus (23-bit one-hot plus RX/RY) and the 4-bit flags register that the control FSM consumes. Also keeps a saturating count of fetched instructions for debug.

## Interface
- `CNT_W`, default 16: width of the instruction-fetch counter.
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `instr_in` in 16: instruction word from code memory.
  - Fields: [15:12] opcode, [11:10] RX, [9:8] RY, [7:0] immediate.
- `ir_load` in 1: IR write enable, driven by a control bit.
- `flags_load` in 1: flags write enable, driven by a control bit.
- `alu_flags_in` in 4: flags from the ALU.
  - Bits: [0] zero, [1] negative, [2] overflow, [3] carry.
- `opcode_out` out 27: decoded opcode bus.
  - [22:0] one-hot instruction class.
  - [24:23] RY.
  - [26:25] RX.
- `imm_out` out 8: IR[7:0].
- `flags_reg` out 4: registered flags, same bit order as `alu_flags_in`.
- `opcode_valid` out 1: high once the IR holds a fetched instruction.
- `fetch_count` out `CNT_W`: number of `ir_load` pulses accepted, saturating.

## Operation
**IR register (16 bits)**
- Reset value: 16'h0000.
- On a rising edge with `ir_load`=1, loads `instr_in`; otherwise holds.

**Decode (combinational from the IR only)**
- `opcode_out[26:25]` = IR[11:10]; `opcode_out[24:23]` = IR[9:8].
- Exactly one bit of [22:0] is set for every IR value. There is no illegal encoding.
- One-hot mapping from IR[15:12]:
  - 0000 → bit0 NOOP.
  - 0001 → INPUT family, selected by IR[9:8]: 00 bit1 INPUTC, 01 bit2 INPUTCF, 10 bit3 INPUTD, 11 bit4 INPUTDF.
  - 0010 → bit5 MOVE.
  - 0011 → bit6 LOADI/LOADP.
  - 0100 → bit7 ADD.
  - 0101 → bit8 ADDI.
  - 0110 → bit9 SUB.
  - 0111 → bit10 SUBI.
  - 1000 → bit11 LOAD.
  - 1001 → bit12 LOADF.
  - 1010 → bit13 STORE.
  - 1011 → bit14 STOREF.
  - 1100 → shift, selected by IR[8]: 0 bit15 SHIFTL, 1 bit16 SHIFTR. IR[9] is ignored.
  - 1101 → bit17 CMP.
  - 1110 → bit18 JUMP.
  - 1111 → branch, selected by IR[9:8]: 00 bit19 BRE/BRZ, 01 bit20 BRNE/BRNZ, 10 bit21 BRG, 11 bit22 BRGE.
- For the INPUT and branch groups, RY is still passed through unchanged on [24:23].

**Flags register**
- Reset value: 4'b0000.
- On a rising edge with `flags_load`=1, loads `alu_flags_in`; otherwise holds.

**opcode_valid**
- Reset value: 0.
- Set on the first accepted `ir_load` and stays 1 until the next reset.

**fetch_count**
- Reset value: 0.
- Increments by 1 on each accepted `ir_load`.
- Saturates at all-ones and never wraps.

**Reset output values**
- `opcode_out` = 27'h0000001 (NOOP, RX=RY=0).
- `imm_out` = 0, `flags_reg` = 0, `opcode_valid` = 0, `fetch_count` = 0.

## Timing
- `ir_load` sampled high at edge N:
  - IR, `opcode_out`, `imm_out` and `opcode_valid` reflect the new instruction immediately after edge N.
  - This gives zero extra cycles, so an FSM in the ID state in cycle N+1 sees the decoded opcode.
- `flags_load` at edge N: `flags_reg` is updated after edge N.
  - A branch decided in a later cycle sees the new flags.
  - A branch decided in the same cycle as the load sees the old flags.
- `ir_load` and `flags_load` in the same cycle: both updates happen independently.
- `instr_in` changing without `ir_load`: no effect on any output.
- `reset` asserted mid-operation: all state clears asynchronously, without waiting for a clock edge.
  - Any `ir_load` or `flags_load` in that cycle is ignored.
  - Release is synchronous to the next edge; the first `ir_load` after release is accepted normally.
- Counter at all-ones plus `ir_load`: the IR loads, the counter holds.

## Test plan
- **Reset:** assert `reset` between edges.
  - Outputs go immediately to `opcode_out`=27'h0000001, `flags_reg`=0, `opcode_valid`=0, `fetch_count`=0.
- **Full decode sweep:** `ir_load` each of the 16 opcodes with RY=00/01/10/11 and RX=2'b10.
  - One-hot bit matches the mapping; [26:25]=2'b10; [24:23]=RY; `imm_out`=IR[7:0].
  - Example: `instr_in`=16'hF6A5 gives bit21 (BRG), RX=01, RY=10, `imm_out`=8'hA5.
- **Hold:** change `instr_in` to 16'h4000 with `ir_load`=0.
  - `opcode_out` unchanged; `fetch_count` unchanged.
- **Flags:**
  - `alu_flags_in`=4'b0011 with `flags_load`=1 → `flags_reg`=4'b0011 after the edge.
  - Next cycle, `alu_flags_in`=4'b1000 with `flags_load`=0 → `flags_reg` stays 4'b0011.
  - Simultaneous `ir_load` of 16'hD000 → bit17 (CMP) and the flags update both occur.
- **Saturation:** with `CNT_W`=4, issue 20 `ir_load` pulses.
  - `fetch_count` climbs to 4'hF and holds; the IR keeps loading.
- **Reset mid-stream:** `ir_load` of 16'h8123, then assert `reset` mid-cycle.
  - Outputs return to reset values at once; `opcode_valid`=0.
  - After release, `ir_load` of 16'h2400 gives bit5 (MOVE), RX=01, `fetch_count`=1.
